// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the exhaustive gate-pair sweep sequencer.
// State encoding is fixed here so lab tops and debug probes can decode it.
package gate_sweep_pkg;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DRIVE  = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   // Error counter must hold 2^n_in, one more bit than the vector itself.
   function automatic int unsigned res_width(input int unsigned n_in);
      return n_in + 1;
   endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle-window counter: counts enabled cycles and flags the HOLD-th one,
// then wraps to zero on its own so the next vector starts a fresh window.
module sweep_settle_timer #(
   parameter int unsigned HOLD = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam int unsigned   CW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [CW-1:0] TC = CW'(HOLD - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expired = en && (cnt_q == TC);

   always_comb begin
      cnt_d = cnt_q;
      if (clear || expired) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep of a gate pair: drives every vector in ascending order,
// lets it settle for HOLD cycles, then compares the two gate outputs.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | after reset; waits for start
//   S_DRIVE  | x held stable while the settle timer runs (HOLD cycles)
//   S_SAMPLE | one cycle: compare a_in/b_in, advance x or finish
//   S_DONE   | results stable, x left at all ones; start restarts
module gate_sweep_ctrl
   import gate_sweep_pkg::*;
#(
   parameter int unsigned N_IN = 2,
   parameter int unsigned HOLD = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   output logic [N_IN-1:0]               x,
   input  logic                          a_in,
   input  logic                          b_in,
   output logic                          busy,
   output logic                          done,
   output logic                          mismatch,
   output logic [res_width(N_IN)-1:0]    err_count,
   output logic [N_IN-1:0]               first_err_vec
);

   localparam int unsigned     EW    = res_width(N_IN);
   localparam logic [N_IN-1:0] X_MAX = '1;

   logic [1:0]      state_q, state_d;
   logic [N_IN-1:0] x_q, x_d;
   logic [EW-1:0]   err_q, err_d;
   logic            mm_q, mm_d;
   logic [N_IN-1:0] fev_q, fev_d;

   logic tmr_clear;
   logic tmr_en;
   logic tmr_expired;

   sweep_settle_timer #(
      .HOLD (HOLD)
   ) u_settle (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmr_clear),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      err_d     = err_q;
      mm_d      = mm_q;
      fev_d     = fev_q;
      tmr_clear = 1'b0;
      tmr_en    = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_DRIVE;
               x_d       = '0;
               err_d     = '0;
               mm_d      = 1'b0;
               fev_d     = '0;
               tmr_clear = 1'b1;
            end
         end
         S_DRIVE: begin
            tmr_en = 1'b1;
            if (tmr_expired) begin
               state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            // Gate outputs are only looked at here, so X/Z elsewhere is harmless.
            if (a_in ^ b_in) begin
               err_d = err_q + EW'(1);
               mm_d  = 1'b1;
               if (!mm_q) begin
                  fev_d = x_q;
               end
            end
            if (x_q == X_MAX) begin
               state_d = S_DONE;
            end else begin
               x_d     = x_q + N_IN'(1);
               state_d = S_DRIVE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         err_q   <= '0;
         mm_q    <= 1'b0;
         fev_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         err_q   <= err_d;
         mm_q    <= mm_d;
         fev_q   <= fev_d;
      end
   end

   assign x             = x_q;
   assign busy          = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
   assign done          = (state_q == S_DONE);
   assign mismatch      = mm_q;
   assign err_count     = err_q;
   assign first_err_vec = fev_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (HOLD=1 and HOLD=3) share stimulus;
// a cycle-count model predicts outputs and a queue holds per-sweep results.
module tb_gate_sweep_ctrl;

   localparam int NV = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, start;
   logic [1:0] x0, x1, fv0, fv1;
   logic       a0, b0, a1, b1;
   logic       busy0, busy1, done0, done1, mm0, mm1;
   logic [2:0] ec0, ec1;

   gate_sweep_ctrl #(.N_IN(2), .HOLD(1)) u0 (
      .clk(clk), .reset(reset), .start(start), .x(x0), .a_in(a0), .b_in(b0),
      .busy(busy0), .done(done0), .mismatch(mm0), .err_count(ec0), .first_err_vec(fv0));

   gate_sweep_ctrl #(.N_IN(2), .HOLD(3)) u1 (
      .clk(clk), .reset(reset), .start(start), .x(x1), .a_in(a1), .b_in(b1),
      .busy(busy1), .done(done1), .mismatch(mm1), .err_count(ec1), .first_err_vec(fv1));

   typedef struct {
      int err;
      int mm;
      int first;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t last_exp[2];

   int   tests = 0;
   int   fails = 0;
   bit   chk_en = 1'b0;

   logic [3:0] next_mask;
   logic [3:0] cur_mask[2];
   bit         act[2];
   int         k[2];
   bit         popped[2];

   function automatic int hold_of(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic int lat_of(input int i);
      return NV * (hold_of(i) + 1);
   endfunction

   function automatic int lowest(input int m);
      for (int b = 0; b < NV; b++) if (m[b]) return b;
      return 0;
   endfunction

   function automatic exp_t result_of(input int m);
      exp_t e;
      e.err   = $countones(m);
      e.mm    = (m != 0) ? 1 : 0;
      e.first = lowest(m);
      return e;
   endfunction

   task automatic chk(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   // Reference: k counts edges since the accepted start; L = 2^N*(HOLD+1) ends the sweep.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            act[i] <= 1'b0;
            k[i]   <= 0;
            if (i == 0) q0.delete(); else q1.delete();
         end else if ((!act[i] || k[i] == lat_of(i)) && start) begin
            act[i]      <= 1'b1;
            k[i]        <= 0;
            popped[i]   <= 1'b0;
            cur_mask[i] <= next_mask;
            if (i == 0) q0.push_back(result_of(int'(next_mask)));
            else        q1.push_back(result_of(int'(next_mask)));
         end else if (act[i] && k[i] < lat_of(i)) begin
            k[i] <= k[i] + 1;
         end
      end
   end

   task automatic check_inst(input int i, input logic [1:0] xv, input logic bz,
                             input logic dn, input logic mmv, input logic [2:0] ecv,
                             input logic [1:0] fvv);
      int   h, l, n, part;
      exp_t e;
      string p;
      h = hold_of(i);
      l = lat_of(i);
      p = $sformatf("u%0d", i);
      if (!act[i]) begin
         chk({p, ".busy_idle"}, bz, 0);
         chk({p, ".done_idle"}, dn, 0);
         chk({p, ".x_idle"}, xv, 0);
         chk({p, ".err_idle"}, ecv, 0);
         chk({p, ".mm_idle"}, mmv, 0);
         chk({p, ".fev_idle"}, fvv, 0);
      end else if (k[i] < l) begin
         n    = k[i] / (h + 1);
         part = int'(cur_mask[i]) & ((1 << n) - 1);
         chk({p, ".busy_run"}, bz, 1);
         chk({p, ".done_run"}, dn, 0);
         chk({p, ".x_run"}, xv, n);
         chk({p, ".err_run"}, ecv, $countones(part));
         chk({p, ".mm_run"}, mmv, (part != 0) ? 1 : 0);
         if (part != 0) chk({p, ".fev_run"}, fvv, lowest(part));
      end else begin
         if (!popped[i]) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
               chk({p, ".sb_empty_at_done"}, 0, 1);
               last_exp[i] = result_of(int'(cur_mask[i]));
            end else begin
               last_exp[i] = (i == 0) ? q0.pop_front() : q1.pop_front();
            end
            popped[i] = 1'b1;
         end
         e = last_exp[i];
         chk({p, ".busy_done"}, bz, 0);
         chk({p, ".done_done"}, dn, 1);
         chk({p, ".x_done"}, xv, NV - 1);
         chk({p, ".err_done"}, ecv, e.err);
         chk({p, ".mm_done"}, mmv, e.mm);
         if (e.mm != 0) chk({p, ".fev_done"}, fvv, e.first);
      end
   endtask

   // Monitor, then drive gate outputs: true NOR pair in SAMPLE, noise elsewhere.
   always @(negedge clk) begin
      if (chk_en) begin
         check_inst(0, x0, busy0, done0, mm0, ec0, fv0);
         check_inst(1, x1, busy1, done1, mm1, ec1, fv1);
      end
      if (act[0] && k[0] < lat_of(0) && (k[0] % 2) == 1) begin
         a0 = ~|x0;
         b0 = (~|x0) ^ cur_mask[0][x0];
      end else begin
         a0 = 1'($urandom);
         b0 = 1'($urandom);
      end
      if (act[1] && k[1] < lat_of(1) && (k[1] % 4) == 3) begin
         a1 = ~|x1;
         b1 = (~|x1) ^ cur_mask[1][x1];
      end else begin
         a1 = 1'($urandom);
         b1 = 1'($urandom);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      next_mask = 4'b0000;
      a0 = 1'b0; b0 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      @(posedge clk);
      #1 chk_en = 1'b1;
      cycles(2);
      reset = 1'b0;
      cycles(2);

      next_mask = 4'b0000; pulse_start(); cycles(20);
      next_mask = 4'b1000; pulse_start(); cycles(20);
      next_mask = 4'b0110; pulse_start();
      cycles(1); pulse_start(); cycles(2); pulse_start(); cycles(20);

      next_mask = 4'b0101; pulse_start(); cycles(3);
      reset = 1'b1; @(negedge clk); reset = 1'b0;
      next_mask = 4'b0011; pulse_start(); cycles(20);

      next_mask = 4'b1001; start = 1'b1; cycles(40); start = 1'b0; cycles(20);

      for (int c = 0; c < 2000; c++) begin
         start     = ($urandom_range(0, 7) == 0);
         reset     = ($urandom_range(0, 99) == 0);
         next_mask = 4'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      reset = 1'b0;
      cycles(20);

      chk("u0.sb_leftover", q0.size(), 0);
      chk("u1.sb_leftover", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
- Sequencer that exhaustively sweeps a small combinational gate pair, for example the 2-input NOR built from gates and its expression-form twin.
- Drives every input vector in ascending order and holds each one for a settle window.
- Samples the two gate outputs and compares them, then counts and records mismatches.
- Sits between a lab top-level and the gate instances; replaces the hand-written #1 stimulus in the existing benches.

Parameters:
- N_IN, 2: number of gate inputs; sweep covers 2^N_IN vectors.
- HOLD, 1: settle cycles per vector before sampling; must be at least 1.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request a sweep; accepted only in IDLE or DONE.
- x, output, N_IN: vector applied to both gates under test.
- a_in, input, 1: output of gate-level implementation.
- b_in, input, 1: output of expression-level implementation.
- busy, output, 1: high while a sweep is running.
- done, output, 1: high in DONE, until the next accepted start or reset.
- mismatch, output, 1: sticky; set if any vector had a_in != b_in.
- err_count, output, N_IN+1: number of mismatching vectors; range 0..2^N_IN.
- first_err_vec, output, N_IN: first vector that mismatched; valid only when mismatch is 1.

Behaviour:
- Reset values (synchronous reset high at an edge):
  - state = IDLE; x = 0; busy = 0; done = 0; mismatch = 0; err_count = 0; first_err_vec = 0; settle counter = 0.
  - Reset overrides start and all other events in the same cycle.
- States: IDLE, DRIVE, SAMPLE, DONE. Encoding is 2 bits and fixed in the package.
- IDLE:
  - start = 1 at edge E0 moves to DRIVE.
  - x = 0, busy = 1, done = 0, settle counter = 0.
  - err_count, mismatch and first_err_vec clear to 0.
- DRIVE:
  - x is held stable; the settle counter increments each cycle.
  - When counter == HOLD-1, go to SAMPLE and reset the counter.
  - DRIVE therefore lasts exactly HOLD cycles.
- SAMPLE (one cycle):
  - a_in and b_in are compared combinationally against the registered x.
  - If they differ: err_count += 1; if mismatch was 0, first_err_vec = x; mismatch = 1.
  - If x == 2^N_IN-1, go to DONE with busy = 0 and done = 1.
  - Otherwise x = x+1 (N_IN-bit increment) and go to DRIVE.
- DONE:
  - x keeps its last vector (all ones); results are stable.
  - start = 1 behaves as in IDLE: restart and clear the results.
- Latency: done rises after edge E0 + 2^N_IN*(HOLD+1). For the defaults that is 8 cycles after the start edge.
- start while busy is ignored: no restart and no effect on counters.
- start held high continuously: a new sweep begins on the first edge in DONE, so done is high for exactly one cycle.
- x wrap-around never happens; the terminal vector exits to DONE.
- err_count cannot overflow; its width covers 2^N_IN.
- Reset mid-sweep: next cycle is IDLE with all reset values; partial results are discarded.
- a_in and b_in are ignored outside SAMPLE. X/Z on them outside SAMPLE must not disturb state.

Decomposition:
- Package gate_sweep_pkg:
  - state encoding localparams S_IDLE=0, S_DRIVE=1, S_SAMPLE=2, S_DONE=3.
  - function for the result width, N_IN+1.
- One natural sub-module, sweep_settle_timer: HOLD-cycle counter with inputs clk, reset, clear, en and output expired.
- FSM, vector register and error bookkeeping stay in gate_sweep_ctrl.

Test Plan:
- Matching gates, defaults: a_in and b_in both driven by NOR(x) → x steps 0,1,2,3; done at cycle 8; err_count = 0; mismatch = 0.
- Faulty b: b_in = NOR(x) except inverted at x = 2'b11 → err_count = 1, mismatch = 1, first_err_vec = 2'b11.
- Two faults: b_in inverted at x = 2'b01 and x = 2'b10 → err_count = 2, first_err_vec = 2'b01.
- start pulses at cycles 2 and 5 of a running sweep → ignored; done still at cycle 8; x sequence unchanged.
- Reset at cycle 4, then start → full restart; x = 0; results cleared; done 8 cycles after the new start.
- HOLD = 3: each x held 3 cycles before its SAMPLE cycle; done at cycle 16. Then start from DONE → results cleared and a new sweep completes identically.
